tx_block: RTL and testbench

// - UART-style serial transmitter. It sits directly upstream of the receive block:

---
 rtl/uart_pkg.sv | 28 ++
 rtl/tx_bit_timer.sv | 42 ++++
 rtl/tx_block.sv | 133 +++++++++++++
 tb/tb_tx_block.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, line levels and settings helpers.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic        START_BIT      = 1'b0;
  localparam logic        STOP_BIT       = 1'b1;
  localparam int unsigned MIN_BIT_PERIOD = 2;
  localparam int unsigned MIN_DATA_SIZE  = 5;
  localparam int unsigned SIZE_WIDTH     = 4;

  // Legal frame sizes pass through; anything else falls back to the full width.
  function automatic logic [SIZE_WIDTH-1:0] clamp_size(
    input logic [SIZE_WIDTH-1:0] size,
    input logic [SIZE_WIDTH-1:0] max_size
  );
    if ((size >= SIZE_WIDTH'(MIN_DATA_SIZE)) && (size <= max_size)) begin
      return size;
    end
    return max_size;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timer: counts 1..i_bp and wraps, with a registered end-of-bit strobe.
module tx_bit_timer #(
  parameter int unsigned BP_WIDTH = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                i_clr,
  input  logic                i_run,
  input  logic                i_run_nxt,
  input  logic [BP_WIDTH-1:0] i_bp,
  output logic                o_bit_end,
  output logic                o_bit_end_nxt_c
);

  logic [BP_WIDTH-1:0] r_cnt;
  logic [BP_WIDTH-1:0] w_cnt_nxt;
  logic                r_bit_end;

  // A clear loads 1 so the first clock of every state already counts.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = BP_WIDTH'(1);
    end else if (i_run) begin
      w_cnt_nxt = r_bit_end ? BP_WIDTH'(1) : r_cnt + BP_WIDTH'(1);
    end
  end

  assign o_bit_end_nxt_c = i_run_nxt && (w_cnt_nxt == i_bp);
  assign o_bit_end       = r_bit_end;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt     <= '0;
      r_bit_end <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_bit_end <= o_bit_end_nxt_c;
    end
  end

endmodule

// File: rtl/tx_block.sv
// UART transmitter: valid/ready byte intake, start/data/stop framing, registered line output.
module tx_block
  import uart_pkg::*;
#(
  parameter int unsigned BP_WIDTH = 14,
  parameter int unsigned DATA_MAX = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_MAX-1:0]   tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [BP_WIDTH-1:0]   bit_period,
  input  logic [SIZE_WIDTH-1:0] data_size,
  output logic                  serial_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [DATA_MAX-1:0]   r_shreg;
  logic [DATA_MAX-1:0]   w_shreg_nxt;
  logic [BP_WIDTH-1:0]   r_bp;
  logic [BP_WIDTH-1:0]   w_bp_nxt;
  logic [SIZE_WIDTH-1:0] r_size;
  logic [SIZE_WIDTH-1:0] w_size_nxt;
  logic [SIZE_WIDTH-1:0] r_bitcnt;
  logic [SIZE_WIDTH-1:0] w_bitcnt_nxt;
  logic                  r_serial;
  logic                  w_serial_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_done;
  logic                  w_done_nxt;

  logic w_accept;
  logic w_last_bit;
  logic w_bit_end;
  logic w_bit_end_nxt;
  logic w_tmr_clr;
  logic w_tmr_run;
  logic w_tmr_run_nxt;

  assign w_accept      = tx_valid && r_ready;
  assign w_last_bit    = (r_bitcnt == (r_size - SIZE_WIDTH'(1)));
  assign w_tmr_clr     = (w_state_nxt != r_state);
  assign w_tmr_run     = (r_state != IDLE);
  assign w_tmr_run_nxt = (w_state_nxt != IDLE);

  tx_bit_timer #(
    .BP_WIDTH (BP_WIDTH)
  ) u_bit_timer (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_clr           (w_tmr_clr),
    .i_run           (w_tmr_run),
    .i_run_nxt       (w_tmr_run_nxt),
    .i_bp            (r_bp),
    .o_bit_end       (w_bit_end),
    .o_bit_end_nxt_c (w_bit_end_nxt)
  );

  // Next state, datapath and look-ahead outputs so every port comes straight from a flop.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bp_nxt     = r_bp;
    w_size_nxt   = r_size;
    w_bitcnt_nxt = r_bitcnt;

    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = START;
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && w_last_bit) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = w_accept ? START : IDLE;
      default: w_state_nxt = IDLE;
    endcase

    if (w_accept) begin
      w_shreg_nxt  = tx_data;
      w_bp_nxt     = (bit_period < BP_WIDTH'(MIN_BIT_PERIOD)) ? BP_WIDTH'(MIN_BIT_PERIOD)
                                                               : bit_period;
      w_size_nxt   = clamp_size(data_size, SIZE_WIDTH'(DATA_MAX));
      w_bitcnt_nxt = '0;
    end else if ((r_state == DATA) && w_bit_end) begin
      w_shreg_nxt  = r_shreg >> 1;
      w_bitcnt_nxt = r_bitcnt + SIZE_WIDTH'(1);
    end

    case (w_state_nxt)
      START:   w_serial_nxt = START_BIT;
      DATA:    w_serial_nxt = w_shreg_nxt[0];
      default: w_serial_nxt = STOP_BIT;
    endcase

    w_done_nxt  = (w_state_nxt == STOP) && w_bit_end_nxt;
    w_ready_nxt = (w_state_nxt == IDLE) || w_done_nxt;
    w_busy_nxt  = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bp     <= '0;
      r_size   <= '0;
      r_bitcnt <= '0;
      r_serial <= STOP_BIT;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bp     <= w_bp_nxt;
      r_size   <= w_size_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_serial <= w_serial_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign serial_out = r_serial;
  assign tx_ready   = r_ready;
  assign tx_busy    = r_busy;
  assign tx_done    = r_done;

endmodule

// File: tb/tb_tx_block.sv
// Directed bench for tx_block: frame table with a line model and receive decode, plus corner sequences.
module tb_tx_block;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [13:0] bit_period;
  logic [3:0]  data_size;
  logic        serial_out;
  logic        tx_busy;
  logic        tx_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_block #(
    .BP_WIDTH (14),
    .DATA_MAX (8)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .bit_period (bit_period),
    .data_size  (data_size),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  size;
    logic [13:0] bp;
    int          nbits;
    int          bp_eff;
    logic [7:0]  exp_rx;
    int          exp_len;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Starts at the negedge of frame cycle 1 and ends at the negedge of the last frame cycle.
  task automatic watch_frame(input int idx, input int bp, input int nbits,
                             input logic [7:0] exp_rx, input int len, input bit scramble);
    int         line_err  = 0;
    int         busy_err  = 0;
    int         ready_err = 0;
    int         done_err  = 0;
    logic [7:0] rx        = 8'h00;
    logic       exp_lvl;
    int         j;
    for (int k = 1; k <= len; k++) begin
      j = (k - 1) / bp;
      if (j == 0)          exp_lvl = 1'b0;
      else if (j <= nbits) exp_lvl = exp_rx[j-1];
      else                 exp_lvl = 1'b1;
      if (serial_out !== exp_lvl)      line_err++;
      if (tx_busy !== 1'b1)            busy_err++;
      if (tx_ready !== (k == len))     ready_err++;
      if (tx_done !== (k == len))      done_err++;
      if ((j >= 1) && (j <= nbits) && (((k - 1) % bp) == (bp / 2))) rx[j-1] = serial_out;
      if (scramble && (k == bp + 1)) begin
        bit_period = 14'd20;
        data_size  = 4'd5;
      end
      if (k < len) @(negedge clk);
    end
    chk("line_bad_cycles", idx, line_err, 0);
    chk("busy_bad_cycles", idx, busy_err, 0);
    chk("ready_bad_cycles", idx, ready_err, 0);
    chk("done_bad_cycles", idx, done_err, 0);
    chk("rx_byte", idx, rx, exp_rx);
  endtask

  task automatic run_vec(input int i);
    @(negedge clk);
    tx_data    = vecs[i].data;
    data_size  = vecs[i].size;
    bit_period = vecs[i].bp;
    tx_valid   = 1'b1;
    chk("ready_idle", i, tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~vecs[i].data;
    watch_frame(i, vecs[i].bp_eff, vecs[i].nbits, vecs[i].exp_rx, vecs[i].exp_len, 1'b1);
    @(negedge clk);
    chk("idle_after", i, {serial_out, tx_busy, tx_ready, tx_done}, 4'b1010);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 4'd8, 14'd10, 8, 10, 8'hA5, 100};
    vecs[1] = '{8'hFF, 4'd5, 14'd4,  5, 4,  8'h1F, 28};
    vecs[2] = '{8'h00, 4'd8, 14'd3,  8, 3,  8'h00, 30};
    vecs[3] = '{8'h55, 4'd8, 14'd2,  8, 2,  8'h55, 20};
    vecs[4] = '{8'hFF, 4'd8, 14'd5,  8, 5,  8'hFF, 50};
    vecs[5] = '{8'h3C, 4'd6, 14'd1,  6, 2,  8'h3C, 16};
    vecs[6] = '{8'hA5, 4'd0, 14'd3,  8, 3,  8'hA5, 30};
    vecs[7] = '{8'h5A, 4'd9, 14'd2,  8, 2,  8'h5A, 20};
    vecs[8] = '{8'h96, 4'd7, 14'd3,  7, 3,  8'h16, 27};
    vecs[9] = '{8'hC3, 4'd5, 14'd0,  5, 2,  8'h03, 14};

    n_rst      = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    bit_period = 14'd10;
    data_size  = 4'd8;
    #12;
    chk("rst_serial_out", 0, serial_out, 1);
    chk("rst_tx_ready", 0, tx_ready, 1);
    chk("rst_tx_busy", 0, tx_busy, 0);
    chk("rst_tx_done", 0, tx_done, 0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i);

    // Reset during the start bit forces the line high before the next clock edge.
    @(negedge clk);
    tx_data    = 8'hA5;
    data_size  = 4'd8;
    bit_period = 14'd10;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_line", 200, serial_out, 0);
    #2 n_rst = 1'b0;
    #1 chk("async_reset", 200, {serial_out, tx_busy, tx_ready, tx_done}, 4'b1010);
    @(negedge clk);
    n_rst = 1'b1;
    run_vec(3);

    // tx_valid held high: second byte follows the first stop bit with no idle clock.
    @(negedge clk);
    tx_data    = 8'h01;
    data_size  = 4'd8;
    bit_period = 14'd4;
    tx_valid   = 1'b1;
    @(negedge clk);
    tx_data = 8'h80;
    watch_frame(100, 4, 8, 8'h01, 40, 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    watch_frame(101, 4, 8, 8'h80, 40, 1'b0);
    @(negedge clk);
    chk("b2b_idle_after", 101, {serial_out, tx_busy, tx_ready, tx_done}, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
